serial_receiver: RTL and testbench

//   UART (8N1) receiver and SUMP command assembler: front end of the serial OLS link.

---
 rtl/serial_receiver.sv | 185 ++++++++++++++++++
 tb/tb_serial_receiver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// UART 8N1 receiver feeding a SUMP command assembler (short: 1 byte, long: opcode + 4 data bytes).
// Publishes opcode/opdata with a one-cycle execute strobe; flags bad stop bits with frameError.
module serial_receiver #(
    parameter int FREQ    = 100000000,
    parameter int RATE    = 115200,
    parameter int TIMEOUT = 10000000
) (
    input  logic        clock,
    input  logic        extReset_n,
    input  logic        rx,
    output logic [7:0]  opcode,
    output logic [31:0] opdata,
    output logic        execute,
    output logic        frameError,
    output logic        rxBusy
);
    localparam int          BITLENGTH = FREQ / RATE;
    localparam logic [15:0] BIT_LAST  = 16'(BITLENGTH - 1);
    localparam logic [15:0] BIT_HALF  = 16'(BITLENGTH / 2 - 1);
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic {CMD_OP, CMD_DATA} cmd_state_t;

    rx_state_t  rx_state, rx_next;
    cmd_state_t cmd_state, cmd_next;

    logic        rx_meta, rx_s;
    logic [15:0] tcount;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        sample, byte_valid, frame_err;

    logic [7:0]  op_stage;
    logic [23:0] data_stage;
    logic [1:0]  idx;
    logic [31:0] idle_cnt;
    logic        exec_next, latch_op, store_byte, publish_short, publish_long;

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        sample     = 1'b0;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_s) rx_next = RX_START;
            RX_START: if (tcount == BIT_HALF) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (tcount == BIT_LAST) begin
                    sample = 1'b1;
                    if (bit_cnt == 3'd7) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                // leaving at mid stop bit leaves half a bit to catch a back-to-back start edge
                if (tcount == BIT_LAST) begin
                    if (rx_s) begin
                        byte_valid = 1'b1;
                        rx_next    = RX_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        rx_next   = RX_WAIT;
                    end
                end
            end
            RX_WAIT:  if (rx_s) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            rx_state   <= RX_IDLE;
            tcount     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            frameError <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            frameError <= frame_err;
            if (rx_next != rx_state || sample || rx_state == RX_IDLE)
                tcount <= '0;
            else
                tcount <= tcount + 16'd1;
            if (sample) begin
                shift   <= {rx_s, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end else if (rx_state != RX_DATA) begin
                bit_cnt <= '0;
            end
        end
    end

    always_comb begin
        cmd_next      = cmd_state;
        exec_next     = 1'b0;
        latch_op      = 1'b0;
        store_byte    = 1'b0;
        publish_short = 1'b0;
        publish_long  = 1'b0;
        case (cmd_state)
            CMD_OP: begin
                if (byte_valid) begin
                    if (!shift[7]) begin
                        publish_short = 1'b1;
                        exec_next     = 1'b1;
                    end else begin
                        latch_op = 1'b1;
                        cmd_next = CMD_DATA;
                    end
                end
            end
            CMD_DATA: begin
                // an arriving byte takes priority over a simultaneous timeout
                if (frame_err) begin
                    cmd_next = CMD_OP;
                end else if (byte_valid) begin
                    if (idx == 2'd3) begin
                        publish_long = 1'b1;
                        exec_next    = 1'b1;
                        cmd_next     = CMD_OP;
                    end else begin
                        store_byte = 1'b1;
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    cmd_next = CMD_OP;
                end
            end
            default: cmd_next = CMD_OP;
        endcase
    end

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            cmd_state  <= CMD_OP;
            execute    <= 1'b0;
            opcode     <= '0;
            opdata     <= '0;
            op_stage   <= '0;
            data_stage <= '0;
            idx        <= '0;
            idle_cnt   <= '0;
        end else begin
            cmd_state <= cmd_next;
            execute   <= exec_next;
            if (cmd_state == CMD_DATA && !byte_valid)
                idle_cnt <= idle_cnt + 32'd1;
            else
                idle_cnt <= '0;
            if (latch_op) begin
                op_stage <= shift;
                idx      <= '0;
            end
            if (store_byte) begin
                case (idx)
                    2'd0:    data_stage[7:0]   <= shift;
                    2'd1:    data_stage[15:8]  <= shift;
                    default: data_stage[23:16] <= shift;
                endcase
                idx <= idx + 2'd1;
            end
            if (publish_short) begin
                opcode <= shift;
                opdata <= '0;
            end
            if (publish_long) begin
                opcode <= op_stage;
                opdata <= {shift, data_stage};
            end
        end
    end

    assign rxBusy = (rx_state != RX_IDLE) | (cmd_state == CMD_DATA);

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed UART frames, expected commands queued and checked by a monitor.
module tb_serial_receiver;
    localparam int FREQ    = 1600;
    localparam int RATE    = 100;
    localparam int TIMEOUT = 200;
    localparam int BL      = FREQ / RATE;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] data;
    } cmd_t;

    logic        clock = 1'b0;
    logic        extReset_n;
    logic        rx;
    logic [7:0]  opcode;
    logic [31:0] opdata;
    logic        execute, frameError, rxBusy;

    cmd_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exec_cnt = 0;
    int   fe_cnt = 0;

    serial_receiver #(.FREQ(FREQ), .RATE(RATE), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .extReset_n(extReset_n), .rx(rx),
        .opcode(opcode), .opdata(opdata), .execute(execute),
        .frameError(frameError), .rxBusy(rxBusy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    initial begin
        cmd_t e;
        forever begin
            @(negedge clock);
            if (execute) begin
                exec_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_execute", {56'd0, opcode}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("opcode", {56'd0, opcode}, {56'd0, e.op});
                    check("opdata", {32'd0, opdata}, {32'd0, e.data});
                end
            end
            if (frameError) fe_cnt++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_clks(BL);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BL);
        end
        rx = stop;
        wait_clks(BL);
        rx = 1'b1;
    endtask

    task automatic expect_cmd(input logic [7:0] op, input logic [31:0] data);
        cmd_t c;
        c.op = op;
        c.data = data;
        exp_q.push_back(c);
    endtask

    task automatic wait_exec(input string name, input int target);
        for (int i = 0; i < BL; i++) begin
            if (exec_cnt >= target) break;
            wait_clks(1);
        end
        check(name, 64'(exec_cnt), 64'(target));
    endtask

    initial begin
        rx = 1'b1;
        extReset_n = 1'b1;
        #3 extReset_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx = i[0];
            wait_clks(1);
        end
        @(negedge clock);
        check("rst_opcode", {56'd0, opcode}, 64'd0);
        check("rst_opdata", {32'd0, opdata}, 64'd0);
        check("rst_execute", {63'd0, execute}, 64'd0);
        check("rst_frameError", {63'd0, frameError}, 64'd0);
        check("rst_rxBusy", {63'd0, rxBusy}, 64'd0);
        rx = 1'b1;
        wait_clks(2);
        extReset_n = 1'b1;
        wait_clks(4 * BL);
        check("idle_no_exec", 64'(exec_cnt), 64'd0);

        // short command
        expect_cmd(8'h01, 32'h0);
        send_byte(8'h01, 1'b1);
        wait_exec("short_latency", 1);
        wait_clks(2 * BL);

        // long command, back to back frames
        expect_cmd(8'hC0, 32'h44332211);
        send_byte(8'hC0, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_exec("long_exec", 2);
        wait_clks(2 * BL);
        check("busy_after_long", {63'd0, rxBusy}, 64'd0);

        // glitch shorter than half a bit
        rx = 1'b0;
        wait_clks(BL / 4);
        rx = 1'b1;
        wait_clks(3 * BL);
        check("glitch_no_exec", 64'(exec_cnt), 64'd2);
        check("glitch_no_fe", 64'(fe_cnt), 64'd0);
        expect_cmd(8'h02, 32'h0);
        send_byte(8'h02, 1'b1);
        wait_exec("after_glitch", 3);
        wait_clks(2 * BL);

        // framing error aborts partial long command
        send_byte(8'h80, 1'b1);
        send_byte(8'hAA, 1'b1);
        check("busy_mid_long", {63'd0, rxBusy}, 64'd1);
        send_byte(8'h55, 1'b0);
        wait_clks(2 * BL);
        check("frame_error_cnt", 64'(fe_cnt), 64'd1);
        expect_cmd(8'h00, 32'h0);
        send_byte(8'h00, 1'b1);
        wait_exec("after_frame_err", 4);
        wait_clks(2 * BL);

        // inter-byte timeout aborts partial long command
        send_byte(8'hC0, 1'b1);
        send_byte(8'h11, 1'b1);
        wait_clks(TIMEOUT + BL);
        check("timeout_busy", {63'd0, rxBusy}, 64'd0);
        expect_cmd(8'h03, 32'h0);
        send_byte(8'h03, 1'b1);
        wait_exec("after_timeout", 5);
        wait_clks(2 * BL);

        // reset in the middle of a long command and a byte
        send_byte(8'hC1, 1'b1);
        rx = 1'b0;
        wait_clks(3 * BL);
        extReset_n = 1'b0;
        wait_clks(2);
        rx = 1'b1;
        @(negedge clock);
        check("midrst_opcode", {56'd0, opcode}, 64'd0);
        check("midrst_rxBusy", {63'd0, rxBusy}, 64'd0);
        wait_clks(1);
        extReset_n = 1'b1;
        wait_clks(12 * BL);
        check("midrst_no_exec", 64'(exec_cnt), 64'd5);
        check("final_fe_cnt", 64'(fe_cnt), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
